// File: rtl/la_debounce_if.sv
// Level-qualifier bus: raw synchronized level and threshold in, debounced level and event strobes out.
interface la_debounce_if #(
  parameter int CW = 8
);
  logic          in;
  logic [CW-1:0] thresh;
  logic          out;
  logic          rise;
  logic          fall;
  logic          busy;
  logic          dbg_state;

  // No valid/ready handshake: in and thresh are sampled every clock; out/rise/fall/busy
  // are registered and valid every cycle outside reset. dbg_state is 1 while qualifying.
  modport master (output in, thresh, input out, rise, fall, busy, dbg_state);
  modport slave  (input in, thresh, output out, rise, fall, busy, dbg_state);
endinterface

// File: rtl/la_debounce.sv
// Debouncer: accepts a new level on `in` only after it has differed from `out`
// for thresh+1 consecutive samples, emitting one-cycle rise/fall strobes.
module la_debounce #(
  parameter          PROP     = "DEFAULT",
  parameter int      CW       = 8,
  parameter bit      RESETVAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  la_debounce_if.slave bus
);

  typedef enum logic {STABLE = 1'b0, QUALIFY = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Technology-specific variants select on PROP; the generic flop implementation is below.
  if (PROP == "DEFAULT") begin : g_generic
  end

  assign bus.dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STABLE;
      cnt      <= '0;
      bus.out  <= RESETVAL;
      bus.rise <= 1'b0;
      bus.fall <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.rise <= 1'b0;
      bus.fall <= 1'b0;
      case (state)
        STABLE: begin
          if (bus.in != bus.out) begin
            if (bus.thresh == '0) begin
              bus.out  <= bus.in;
              bus.rise <= bus.in;
              bus.fall <= ~bus.in;
              cnt      <= '0;
            end else begin
              cnt      <= {{(CW-1){1'b0}}, 1'b1};
              bus.busy <= 1'b1;
              state    <= QUALIFY;
            end
          end else begin
            cnt <= '0;
          end
        end
        QUALIFY: begin
          if (bus.in == bus.out) begin
            cnt      <= '0;
            bus.busy <= 1'b0;
            state    <= STABLE;
          end else if (cnt >= bus.thresh) begin
            // >= so a threshold lowered below cnt still terminates on this sample
            bus.out  <= bus.in;
            bus.rise <= bus.in;
            bus.fall <= ~bus.in;
            cnt      <= '0;
            bus.busy <= 1'b0;
            state    <= STABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt      <= '0;
          bus.busy <= 1'b0;
          state    <= STABLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_la_debounce.sv
// Self-checking bench for la_debounce: vector table plus hand-written long-window sequences.
module tb_la_debounce;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;

  la_debounce_if #(.CW(CW)) bus ();

  la_debounce #(
    .PROP     ("DEFAULT"),
    .CW       (CW),
    .RESETVAL (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          i;
    logic [CW-1:0] t;
    logic [3:0]    e;   // {out, rise, fall, busy}
    string         name;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic add(input logic r, input logic i, input logic [CW-1:0] t,
                     input logic [3:0] e, input string name);
    vec_t v;
    v.r = r; v.i = i; v.t = t; v.e = e; v.name = name;
    vecs.push_back(v);
  endtask

  // scoreboard: pop one expectation and compare against the registered outputs
  task automatic check_out(input string name, input int idx);
    logic [3:0] exp, act;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: scoreboard empty", name, idx);
      return;
    end
    exp = exp_q.pop_front();
    act = {bus.out, bus.rise, bus.fall, bus.busy};
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: out/rise/fall/busy got %b expected %b", name, idx, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1ns after the rising edge
  task automatic step(input logic r, input logic i, input logic [CW-1:0] t,
                      input logic [3:0] e, input string name, input int idx);
    @(negedge clk);
    rst        = r;
    bus.in     = i;
    bus.thresh = t;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(name, idx);
  endtask

  initial begin
    rst        = 1'b1;
    bus.in     = 1'b1;
    bus.thresh = 8'd3;
    #1;
    exp_q.push_back(4'b0000);
    check_out("reset_async", 0);

    // reset held with in=1, then release with in=0
    for (int k = 0; k < 5; k++) add(1, 1, 3, 4'b0000, "reset_hold");
    add(0, 0, 3, 4'b0000, "reset_release");
    add(0, 0, 3, 4'b0000, "reset_release");
    // clean rise, thresh=3
    for (int k = 0; k < 3; k++) add(0, 1, 3, 4'b0001, "rise_busy");
    add(0, 1, 3, 4'b1100, "rise_edge");
    add(0, 1, 3, 4'b1000, "rise_after");
    // clean fall, thresh=3
    for (int k = 0; k < 3; k++) add(0, 0, 3, 4'b1001, "fall_busy");
    add(0, 0, 3, 4'b0010, "fall_edge");
    add(0, 0, 3, 4'b0000, "fall_after");
    // glitch of 3 cycles with thresh=3 is rejected
    for (int k = 0; k < 3; k++) add(0, 1, 3, 4'b0001, "glitch_busy");
    add(0, 0, 3, 4'b0000, "glitch_drop");
    add(0, 0, 3, 4'b0000, "glitch_after");
    // single-cycle glitch with thresh=1
    add(0, 1, 1, 4'b0001, "glitch1_busy");
    add(0, 0, 1, 4'b0000, "glitch1_drop");
    // thresh=0 follower, toggling every cycle
    for (int k = 0; k < 8; k++)
      add(0, (k % 2 == 0), 0, (k % 2 == 0) ? 4'b1100 : 4'b0010, "zero_follow");
    add(0, 0, 0, 4'b0000, "zero_hold");
    // threshold shrink mid-qualification
    for (int k = 0; k < 10; k++) add(0, 1, 200, 4'b0001, "shrink_busy");
    add(0, 1, 4, 4'b1100, "shrink_edge");
    add(0, 1, 4, 4'b1000, "shrink_after");
    add(0, 0, 0, 4'b0010, "shrink_back");
    add(0, 0, 0, 4'b0000, "shrink_idle");
    // reset mid-qualification restarts the window
    for (int k = 0; k < 3; k++) add(0, 1, 5, 4'b0001, "rstmid_busy");
    add(1, 1, 5, 4'b0000, "rstmid_reset");
    for (int k = 0; k < 5; k++) add(0, 1, 5, 4'b0001, "rstmid_requal");
    add(0, 1, 5, 4'b1100, "rstmid_edge");
    add(0, 1, 5, 4'b1000, "rstmid_after");

    for (int n = 0; n < vecs.size(); n++)
      step(vecs[n].r, vecs[n].i, vecs[n].t, vecs[n].e, vecs[n].name, n);

    // maximum threshold: 256 consecutive samples needed (out is 1 here)
    for (int k = 0; k < 255; k++) step(0, 0, 8'd255, 4'b1001, "max_busy", k);
    step(0, 0, 8'd255, 4'b0010, "max_edge", 0);
    step(0, 0, 8'd255, 4'b0000, "max_after", 0);

    // raising thresh mid-window extends it to the new thresh+1 samples
    for (int k = 0; k < 2; k++) step(0, 1, 8'd2, 4'b0001, "raise_busy", k);
    for (int k = 0; k < 4; k++) step(0, 1, 8'd6, 4'b0001, "raise_ext", k);
    step(0, 1, 8'd6, 4'b1100, "raise_edge", 0);
    step(0, 1, 8'd6, 4'b1000, "raise_after", 0);

    // a randomized glitch shorter than thresh+1 never moves out
    for (int g = 0; g < 4; g++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) step(0, 0, 8'd6, 4'b1001, "rand_glitch", k);
      step(0, 1, 8'd6, 4'b1000, "rand_glitch_end", g);
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
